// File: rtl/vc_trace_pkg.sv
// Shared types and entry-layout helpers for the multi-channel trace buffer.
// Decoders and benches use the same offset functions the capture logic does.
package vc_trace_pkg;

  typedef enum logic [1:0] {
    CH_IDLE    = 2'b00,
    CH_FIRE    = 2'b01,
    CH_STALL   = 2'b10,
    CH_BLOCKED = 2'b11
  } ch_status_e;

  typedef enum logic [1:0] {
    FSM_IDLE  = 2'b00,
    FSM_ARMED = 2'b01,
    FSM_TRIG  = 2'b10,
    FSM_DONE  = 2'b11
  } trace_state_e;

  function automatic int entry_nbits(int nchannels, int msg_nbits, int cycle_nbits);
    return cycle_nbits + nchannels * (2 + msg_nbits);
  endfunction

  // Channel fields are packed from ch0 upward; the cycle stamp sits above all of them.
  function automatic int msg_lsb(int ch, int msg_nbits);
    return ch * (2 + msg_nbits);
  endfunction

  function automatic int status_lsb(int ch, int msg_nbits);
    return ch * (2 + msg_nbits) + msg_nbits;
  endfunction

  function automatic int stamp_lsb(int nchannels, int msg_nbits);
    return nchannels * (2 + msg_nbits);
  endfunction

  function automatic ch_status_e status_of(logic val, logic rdy);
    case ({val, rdy})
      2'b11:   return CH_FIRE;
      2'b10:   return CH_STALL;
      2'b01:   return CH_IDLE;
      default: return CH_BLOCKED;
    endcase
  endfunction

endpackage

// File: rtl/vc_trace_ring.sv
// Circular entry store: one synchronous write port, one combinational read port.
// A push into a full ring overwrites the oldest entry instead of stalling.
module vc_trace_ring #(
  parameter int p_depth = 16,
  parameter int p_width = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         push,
  input  logic [p_width-1:0]           wdata,
  input  logic                         pop,
  output logic [p_width-1:0]           rdata,
  output logic [$clog2(p_depth+1)-1:0] count
);

  localparam int PW = $clog2(p_depth);
  localparam int CW = $clog2(p_depth + 1);

  logic [p_width-1:0] mem [p_depth];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               full;

  assign full  = (count == CW'(p_depth));
  assign rdata = mem[rd_ptr];

  // NOTE: storage has no reset; only pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PW'(1);
      if (full) rd_ptr <= rd_ptr + PW'(1);
      else      count  <= count + CW'(1);
    end else if (pop && (count != '0)) begin
      rd_ptr <= rd_ptr + PW'(1);
      count  <= count - CW'(1);
    end
  end

endmodule

// File: rtl/vc_trace_buffer.sv
// Multi-channel val/rdy trace capture with pre/post-trigger windows and
// oldest-first val/rdy readout. Tracing never backpressures the traced DUT.
module vc_trace_buffer
  import vc_trace_pkg::*;
#(
  parameter int p_nchannels   = 4,
  parameter int p_msg_nbits   = 8,
  parameter int p_depth       = 16,
  parameter int p_cycle_nbits = 32,
  localparam int E  = entry_nbits(p_nchannels, p_msg_nbits, p_cycle_nbits),
  localparam int PW = $clog2(p_depth + 1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [p_nchannels-1:0]             ch_val,
  input  logic [p_nchannels-1:0]             ch_rdy,
  input  logic [p_nchannels*p_msg_nbits-1:0] ch_msg,
  input  logic                               cfg_mode,
  input  logic [PW-1:0]                      cfg_post,
  input  logic                               arm,
  input  logic                               trig,
  output logic                               rd_val,
  input  logic                               rd_rdy,
  output logic [E-1:0]                       rd_entry,
  output logic                               busy,
  output logic                               done,
  output logic [p_cycle_nbits-1:0]           cycles
);

  localparam logic [PW-1:0] MAX_POST = PW'(p_depth - 1);

  trace_state_e  state;
  logic [PW-1:0] remain;
  logic [PW-1:0] post_clamp;
  logic [E-1:0]  entry;
  logic [PW-1:0] count;
  logic          qual;
  logic          push;
  logic          pop;
  logic          clear;

  always_ff @(posedge clk) begin
    if (reset) cycles <= '0;
    else       cycles <= cycles + p_cycle_nbits'(1);
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    entry = '0;
    entry[stamp_lsb(p_nchannels, p_msg_nbits) +: p_cycle_nbits] = cycles;
    for (int i = 0; i < p_nchannels; i++) begin
      entry[msg_lsb(i, p_msg_nbits) +: p_msg_nbits] = ch_msg[i*p_msg_nbits +: p_msg_nbits];
      entry[status_lsb(i, p_msg_nbits) +: 2]        = status_of(ch_val[i], ch_rdy[i]);
    end
  end

  assign qual       = !cfg_mode || (|ch_val);
  assign post_clamp = (cfg_post > MAX_POST) ? MAX_POST : cfg_post;

  // The trigger cycle is recorded even when mode 1 would otherwise skip it.
  assign push  = ((state == FSM_ARMED) && (qual || trig)) || ((state == FSM_TRIG) && qual);
  assign clear = arm && ((state == FSM_IDLE) || (state == FSM_DONE));
  assign pop   = (state == FSM_DONE) && rd_rdy && !clear;

  assign rd_val = (state == FSM_DONE) && (count != '0);
  assign busy   = (state == FSM_ARMED) || (state == FSM_TRIG);
  assign done   = (state == FSM_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FSM_IDLE;
      remain <= '0;
    end else begin
      case (state)
        FSM_IDLE: begin
          if (arm) state <= FSM_ARMED;
        end
        FSM_ARMED: begin
          if (trig) begin
            remain <= post_clamp;
            state  <= (post_clamp == '0) ? FSM_DONE : FSM_TRIG;
          end
        end
        FSM_TRIG: begin
          if (qual) begin
            remain <= remain - PW'(1);
            if (remain == PW'(1)) state <= FSM_DONE;
          end
        end
        FSM_DONE: begin
          if (arm) state <= FSM_ARMED;
        end
        default: state <= FSM_IDLE;
      endcase
    end
  end

  vc_trace_ring #(
    .p_depth (p_depth),
    .p_width (E)
  ) u_ring (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .wdata (entry),
    .pop   (pop),
    .rdata (rd_entry),
    .count (count)
  );

endmodule

// File: tb/tb_vc_trace_buffer.sv
// Directed bench for vc_trace_buffer with 2 channels, 8-bit msgs, depth 8.
// Expected entries are hand-built from the cycle at which each stimulus was applied.
module tb_vc_trace_buffer;

  localparam int NCH = 2;
  localparam int MB  = 8;
  localparam int DEP = 8;
  localparam int CB  = 32;
  localparam int E   = CB + NCH * (2 + MB);
  localparam int PW  = $clog2(DEP + 1);

  logic               clk = 1'b0;
  logic               reset;
  logic [NCH-1:0]     ch_val;
  logic [NCH-1:0]     ch_rdy;
  logic [NCH*MB-1:0]  ch_msg;
  logic               cfg_mode;
  logic [PW-1:0]      cfg_post;
  logic               arm;
  logic               trig;
  logic               rd_val;
  logic               rd_rdy;
  logic [E-1:0]       rd_entry;
  logic               busy;
  logic               done;
  logic [CB-1:0]      cycles;

  int n_checks = 0;
  int n_fails  = 0;
  int tb_cyc   = 0;

  always #5 clk = ~clk;

  vc_trace_buffer #(
    .p_nchannels   (NCH),
    .p_msg_nbits   (MB),
    .p_depth       (DEP),
    .p_cycle_nbits (CB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ch_val   (ch_val),
    .ch_rdy   (ch_rdy),
    .ch_msg   (ch_msg),
    .cfg_mode (cfg_mode),
    .cfg_post (cfg_post),
    .arm      (arm),
    .trig     (trig),
    .rd_val   (rd_val),
    .rd_rdy   (rd_rdy),
    .rd_entry (rd_entry),
    .busy     (busy),
    .done     (done),
    .cycles   (cycles)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, tb_cyc);
    end
  endtask

  // Advance one clock; tb_cyc then equals the DUT cycle counter for a correct design.
  task automatic step();
    @(posedge clk);
    #1;
    tb_cyc++;
  endtask

  task automatic step_to(input int t);
    while (tb_cyc < t) step();
  endtask

  task automatic defaults();
    ch_val   = '0;
    ch_rdy   = '1;
    ch_msg   = '0;
    cfg_mode = 1'b0;
    cfg_post = '0;
    arm      = 1'b0;
    trig     = 1'b0;
    rd_rdy   = 1'b0;
  endtask

  task automatic do_reset();
    defaults();
    reset = 1'b1;
    repeat (3) step();
    reset  = 1'b0;
    tb_cyc = 0;
  endtask

  function automatic logic [E-1:0] mk(input int stamp, input logic [1:0] s1, input logic [7:0] m1,
                                      input logic [1:0] s0, input logic [7:0] m0);
    return {CB'(stamp), s1, m1, s0, m0};
  endfunction

  initial begin
    logic [E-1:0] exp_e [4];

    // Reset state and free-running counter
    do_reset();
    check("reset_rd_val", 64'(rd_val), 64'd0);
    check("reset_busy",   64'(busy),   64'd0);
    check("reset_done",   64'(done),   64'd0);
    for (int i = 0; i < 3; i++) begin
      check("cycles_count", 64'(cycles), 64'(i));
      step();
    end

    // Mode 0 window: arm at 5, trig at 20, post 3 -> done at 24, stamps 16..23
    do_reset();
    step_to(5);  arm = 1'b1; step(); arm = 1'b0;
    check("armed_busy", 64'(busy), 64'd1);
    step_to(20); trig = 1'b1; cfg_post = PW'(3); step(); trig = 1'b0;
    check("trig_busy", 64'(busy), 64'd1);
    step_to(23);
    check("m0_done_early", 64'(done), 64'd0);
    step();
    check("m0_done_24", 64'(done), 64'd1);
    check("m0_busy_24",  64'(busy), 64'd0);
    rd_rdy = 1'b1;
    for (int i = 0; i < DEP; i++) begin
      check("m0_rd_val", 64'(rd_val), 64'd1);
      check("m0_entry",  64'(rd_entry), 64'(mk(16 + i, 2'b00, 8'h00, 2'b00, 8'h00)));
      step();
    end
    check("m0_empty", 64'(rd_val), 64'd0);
    check("m0_stay_done", 64'(done), 64'd1);

    // Mode 1: ch0 fires at 10/12/14, trig at 15 with post 0; also hold rd_rdy low 3 cycles
    do_reset();
    cfg_mode = 1'b1;
    step_to(5);  arm = 1'b1; step(); arm = 1'b0;
    step_to(10); ch_val = 2'b01; ch_msg = 16'h00A1; step(); ch_val = '0; ch_msg = '0;
    step_to(12); ch_val = 2'b01; ch_msg = 16'h00A2; step(); ch_val = '0; ch_msg = '0;
    step_to(14); ch_val = 2'b01; ch_msg = 16'h00A3; step(); ch_val = '0; ch_msg = '0;
    check("m1_pre_done", 64'(done), 64'd0);
    trig = 1'b1; step(); trig = 1'b0;
    check("m1_done_16", 64'(done), 64'd1);
    exp_e[0] = mk(10, 2'b00, 8'h00, 2'b01, 8'hA1);
    exp_e[1] = mk(12, 2'b00, 8'h00, 2'b01, 8'hA2);
    exp_e[2] = mk(14, 2'b00, 8'h00, 2'b01, 8'hA3);
    exp_e[3] = mk(15, 2'b00, 8'h00, 2'b00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      check("hold_rd_val", 64'(rd_val), 64'd1);
      check("hold_entry",  64'(rd_entry), 64'(exp_e[0]));
      step();
    end
    rd_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("m1_rd_val", 64'(rd_val), 64'd1);
      check("m1_entry",  64'(rd_entry), 64'(exp_e[i]));
      step();
    end
    check("m1_empty", 64'(rd_val), 64'd0);

    // Stall then blocked on ch1, mode 0
    do_reset();
    step_to(2); arm = 1'b1; step(); arm = 1'b0;
    step_to(4); ch_val = 2'b10; ch_rdy = 2'b01; step();
    ch_val = 2'b00; ch_rdy = 2'b01; trig = 1'b1; step();
    defaults();
    rd_rdy = 1'b1;
    check("st_entry3", 64'(rd_entry), 64'(mk(3, 2'b00, 8'h00, 2'b00, 8'h00)));
    step();
    check("st_ch1_stall",   64'(rd_entry[19:18]), 64'(2'b10));
    check("st_ch0_idle",    64'(rd_entry[9:8]),   64'(2'b00));
    check("st_stamp4",      64'(rd_entry[E-1 -: CB]), 64'd4);
    step();
    check("st_ch1_blocked", 64'(rd_entry[19:18]), 64'(2'b11));
    check("st_stamp5",      64'(rd_entry[E-1 -: CB]), 64'd5);
    step();
    check("st_empty", 64'(rd_val), 64'd0);

    // Post count clamps to depth-1: trig at 10 with post 9 -> done at 18, stamps 10..17
    do_reset();
    step_to(2);  arm = 1'b1; step(); arm = 1'b0;
    step_to(10); trig = 1'b1; cfg_post = PW'(9); step(); trig = 1'b0;
    step_to(17);
    check("clamp_done_early", 64'(done), 64'd0);
    step();
    check("clamp_done_18", 64'(done), 64'd1);
    rd_rdy = 1'b1;
    for (int i = 0; i < DEP; i++) begin
      check("clamp_stamp", 64'(rd_entry[E-1 -: CB]), 64'(10 + i));
      step();
    end
    check("clamp_empty", 64'(rd_val), 64'd0);

    // Reset mid-TRIG, then simultaneous arm+trig loses the trigger
    do_reset();
    step_to(2); arm = 1'b1; step(); arm = 1'b0;
    step_to(5); trig = 1'b1; cfg_post = PW'(5); step(); trig = 1'b0;
    step_to(7);
    check("mid_trig_busy", 64'(busy), 64'd1);
    reset = 1'b1; step(); reset = 1'b0; tb_cyc = 0;
    check("rst_busy",   64'(busy),   64'd0);
    check("rst_rd_val", 64'(rd_val), 64'd0);
    check("rst_done",   64'(done),   64'd0);
    arm = 1'b1; trig = 1'b1; step(); arm = 1'b0; trig = 1'b0;
    repeat (10) step();
    check("armtrig_busy", 64'(busy), 64'd1);
    check("armtrig_done", 64'(done), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/vc_trace_buffer.md
# vc_trace_buffer

On-chip, multi-channel trace capture buffer, the parametrised successor to the `vc_Trace` line-tracing helper. It samples N val/rdy channels every cycle and stores cycle-stamped snapshots in a circular buffer, with pre-/post-trigger windows. After capture, the recorded window is read out oldest-first over a val/rdy port. It sits beside a DUT in test harnesses and synthesised builds where DPI line tracing is unavailable.

## Interface
- `p_nchannels`, 4: number of traced val/rdy channels.
- `p_msg_nbits`, 8: message bits captured per channel.
- `p_depth`, 16: buffer entries; power of two, ≥2.
- `p_cycle_nbits`, 32: width of the cycle stamp.
- Entry width `E = p_cycle_nbits + p_nchannels*(2+p_msg_nbits)`. Field layout, MSB first: cycle stamp, then for each channel from the highest index down to ch0 a 2-bit status followed by the msg.
- `clk`  in  1  clock; single clock domain.
- `reset`  in  1  synchronous, active-high.
- `ch_val`  in  p_nchannels  per-channel valid.
- `ch_rdy`  in  p_nchannels  per-channel ready.
- `ch_msg`  in  p_nchannels*p_msg_nbits  per-channel message; ch0 in the LSBs.
- `cfg_mode`  in  1  0 = record every cycle; 1 = record only cycles where any `ch_val` is high.
- `cfg_post`  in  clog2(p_depth+1)  post-trigger entry count; sampled when the trigger fires.
- `arm`  in  1  start a capture (pulse).
- `trig`  in  1  trigger event.
- `rd_val`  out  1  readout entry valid.
- `rd_rdy`  in  1  readout consumer ready.
- `rd_entry`  out  E  oldest unread entry.
- `busy`  out  1  high in ARMED or TRIG.
- `done`  out  1  high in DONE.
- `cycles`  out  p_cycle_nbits  free-running cycle counter.

## Operation
- Channel status encoding:
  - 00: idle (!val, rdy).
  - 01: fire (val & rdy).
  - 10: stall (val & !rdy).
  - 11: blocked (!val & !rdy).
- FSM states are IDLE, ARMED, TRIG and DONE.
- IDLE:
  - `arm` moves to ARMED and clears `wr_ptr`, `rd_ptr` and `count`.
  - `trig` is ignored.
- ARMED (pre-trigger window):
  - A qualifying cycle writes its entry at `wr_ptr`, and `wr_ptr` wraps mod `p_depth`.
  - When `count == p_depth`, the oldest entry is overwritten: `rd_ptr` advances and `count` saturates.
  - On `trig`, the trigger cycle is always recorded, regardless of mode. `remain` is loaded with min(`cfg_post`, `p_depth-1`). The FSM goes to TRIG, or directly to DONE if that value is 0.
- TRIG:
  - Qualifying cycles are recorded with the same overwrite rule.
  - `remain` decrements on each record; the write that brings it to 0 moves the FSM to DONE.
  - `trig` and `arm` are ignored.
- DONE:
  - `rd_val = (count != 0)` and `rd_entry = mem[rd_ptr]`.
  - `rd_val & rd_rdy` pops: `rd_ptr++` (wrapping) and `count--`.
  - No recording takes place.
  - `arm` re-arms and discards unread entries.
  - When empty, the block stays in DONE with `rd_val` low.
- `cycles` increments every cycle, wraps mod 2^`p_cycle_nbits`, and is cleared only by reset.
- The entry's cycle stamp is the value of `cycles` in the sampled cycle.

## Timing
- Reset values:
  - State is IDLE.
  - `rd_val`=0, `busy`=0, `done`=0, `cycles`=0.
  - Pointers and `count` are 0.
  - Storage is not cleared.
- Capture: channel inputs in cycle t are written at the posedge ending cycle t. There is no input registering.
- `done` rises the cycle after the final write.
- `rd_val` and `rd_entry` are valid in the first DONE cycle.
- `rd_entry` is combinational from storage. It must remain stable while `rd_val & !rd_rdy`.
- Readout sustains one entry per cycle with `rd_rdy` held high.
- `arm` and `trig` in the same cycle from IDLE: ARMED only; the trigger is lost.
- Reset asserted in any state returns the block to IDLE on the next edge and drops `rd_val`.
- Full (`count == p_depth`) while recording: overwrite, not stall. Tracing never backpressures the DUT.

## Structure
- Shared package `vc_trace_pkg` holds:
  - the status enum (IDLE/FIRE/STALL/BLOCKED);
  - the FSM state enum;
  - entry field offset/width constant functions for use by the bench and decoders.
- One natural sub-module: `vc_trace_ring`, a `p_depth`×E storage array with one synchronous write port, one combinational read port and wrapping pointers.
- The FSM, counters and status encoding live in the top level.

## Test plan
All scenarios use `p_nchannels`=2, `p_msg_nbits`=8, `p_depth`=8.

- Reset for 3 cycles, then release -> `rd_val`/`busy`/`done` are 0 and `cycles` reads 0,1,2,… after release.
- Mode 0, `arm` at cycle 5, `trig` at cycle 20 with `cfg_post`=3 -> `done` at cycle 24; readout gives 8 entries stamped 16..23 in order, then `rd_val`=0.
- Mode 1, ch0 fires msgs 0xA1/0xA2/0xA3 at cycles 10/12/14 and no other val, `trig` at 15 with `cfg_post`=0 -> 4 entries:
  - stamps 10, 12, 14 with ch0 status 01 and msgs A1/A2/A3;
  - stamp 15 with ch0 status 00.
- ch1 val=1/rdy=0 at one cycle and val=0/rdy=0 at the next, mode 0 -> ch1 status 10 then 11.
- In DONE, hold `rd_rdy` low 3 cycles -> `rd_entry` is unchanged and `rd_val` stays high; the first pop happens the cycle `rd_rdy` rises.
- Assert reset mid-TRIG -> next cycle IDLE with `busy`=0 and `rd_val`=0. Then `arm` and `trig` in the same cycle -> `busy`=1 with `done` still 0 after 10 cycles.
